// File: rtl/decoder_scan_pkg.sv
// Shared types for the 3-to-8 decoder scan sequencer.
package decoder_scan_pkg;

   localparam int NUM_CH = 8;

   typedef logic [2:0] chan_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } state_t;

endpackage

// File: rtl/next_channel_finder.sv
// Combinational cyclic search for the next enabled decoder channel above ptr.
module next_channel_finder
   import decoder_scan_pkg::*;
(
   input  chan_t             ptr,
   input  logic [NUM_CH-1:0] mask,
   output chan_t             next,
   output logic              wrap,
   output logic              any
);

   // Scan offsets from far to near so the nearest set bit above ptr wins;
   // offset NUM_CH folds back onto ptr itself for a single-bit mask.
   always_comb begin
      next = ptr;
      for (int i = NUM_CH; i >= 1; i--) begin
         if (mask[chan_t'(ptr + chan_t'(i))]) begin
            next = chan_t'(ptr + chan_t'(i));
         end
      end
   end

   assign any  = |mask;
   assign wrap = any && (next <= ptr);

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Registered slot sequencer driving the enable and select lines of a 3-to-8 decoder.
module decoder_scan_sequencer
   import decoder_scan_pkg::*;
#(
   parameter int SLOT_CYC  = 100000,
   parameter int BLANK_CYC = 1000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic              step,
   input  logic [NUM_CH-1:0] mask,
   output logic              e,
   output logic              a,
   output logic              b,
   output logic              c,
   output logic              slot_start,
   output logic              frame_done
);

   localparam int CNT_W = $clog2(SLOT_CYC);
   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYC - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   chan_t            ptr, ptr_nxt;
   chan_t            sel, sel_nxt;
   logic             step_slot, step_slot_nxt;
   logic             e_nxt, slot_start_nxt, frame_done_nxt;
   logic             begin_slot;
   chan_t            next;
   logic             wrap, any;

   next_channel_finder u_finder (
      .ptr  (ptr),
      .mask (mask),
      .next (next),
      .wrap (wrap),
      .any  (any)
   );

   assign a = sel[2];
   assign b = sel[1];
   assign c = sel[0];

   // Next-state and next-output logic; every output is computed one cycle ahead.
   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      ptr_nxt        = ptr;
      sel_nxt        = sel;
      step_slot_nxt  = step_slot;
      e_nxt          = e;
      slot_start_nxt = 1'b0;
      frame_done_nxt = 1'b0;
      begin_slot     = 1'b0;
      case (state)
         IDLE: begin
            e_nxt = 1'b0;
            if (any && (run || step)) begin
               begin_slot    = 1'b1;
               step_slot_nxt = !run;
            end
         end
         BLANK: begin
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == BLANK_LAST) begin
               state_nxt = DRIVE;
               e_nxt     = 1'b1;
            end
         end
         DRIVE: begin
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == SLOT_LAST) begin
               // Wrap is judged against the mask seen at the slot boundary,
               // whether the scan continues or parks in IDLE.
               frame_done_nxt = wrap;
               if (run && any && !step_slot) begin
                  begin_slot = 1'b1;
               end else begin
                  state_nxt = IDLE;
                  e_nxt     = 1'b0;
                  cnt_nxt   = '0;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            e_nxt     = 1'b0;
         end
      endcase
      if (begin_slot) begin
         ptr_nxt        = next;
         sel_nxt        = next;
         cnt_nxt        = '0;
         slot_start_nxt = 1'b1;
         if (BLANK_CYC == 0) begin
            state_nxt = DRIVE;
            e_nxt     = 1'b1;
         end else begin
            state_nxt = BLANK;
            e_nxt     = 1'b0;
         end
      end
   end

   // State, counter and output registers; ptr starts at the top channel so the
   // first search lands on the lowest enabled one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         ptr        <= chan_t'(NUM_CH - 1);
         sel        <= '0;
         step_slot  <= 1'b0;
         e          <= 1'b0;
         slot_start <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         ptr        <= ptr_nxt;
         sel        <= sel_nxt;
         step_slot  <= step_slot_nxt;
         e          <= e_nxt;
         slot_start <= slot_start_nxt;
         frame_done <= frame_done_nxt;
      end
   end

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Self-checking bench for decoder_scan_sequencer with a slot-level reference model.
module tb_decoder_scan_sequencer;

   localparam int SLOT  = 8;
   localparam int BLANK = 2;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic       run   = 1'b0;
   logic       step  = 1'b0;
   logic [7:0] mask  = 8'h00;
   logic       e, a, b, c, slot_start, frame_done;

   int total = 0;
   int bad   = 0;

   // Reference model: busy flag, position inside the slot, channel pointer.
   bit         m_busy;
   bit         m_step;
   int         m_pos;
   int         m_ptr;
   logic       exp_e;
   logic [2:0] exp_abc;
   logic       exp_ss;
   logic       exp_fd;

   decoder_scan_sequencer #(.SLOT_CYC(SLOT), .BLANK_CYC(BLANK)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .run        (run),
      .step       (step),
      .mask       (mask),
      .e          (e),
      .a          (a),
      .b          (b),
      .c          (c),
      .slot_start (slot_start),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic int ref_next(input int p, input logic [7:0] m);
      for (int k = 1; k <= 8; k++) begin
         if (m[(p + k) % 8]) return (p + k) % 8;
      end
      return p;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_step = 0; m_pos = 0; m_ptr = 7;
      exp_e = 0; exp_abc = 3'b000; exp_ss = 0; exp_fd = 0;
   endtask

   // Advance the model across the coming rising edge using the current inputs.
   task automatic model_step();
      int n;
      exp_ss = 0;
      exp_fd = 0;
      if (!m_busy) begin
         if (mask != 0 && (run || step)) begin
            m_ptr = ref_next(m_ptr, mask);
            m_busy = 1; m_pos = 0; m_step = !run;
            exp_ss = 1; exp_abc = 3'(m_ptr);
         end
      end else if (m_pos == SLOT - 1) begin
         n = ref_next(m_ptr, mask);
         exp_fd = (mask != 0) && (n <= m_ptr);
         if (run && mask != 0 && !m_step) begin
            m_ptr = n; m_pos = 0;
            exp_ss = 1; exp_abc = 3'(m_ptr);
         end else begin
            m_busy = 0;
         end
      end else begin
         m_pos++;
      end
      exp_e = m_busy && (m_pos >= BLANK);
   endtask

   task automatic tick(input logic r, input logic s, input logic [7:0] m);
      run = r; step = s; mask = m;
      model_step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      run = 1; step = 0; mask = 8'hFF;
      #1 rst_n = 0;
      repeat (3) begin
         @(negedge clk);
         total++;
         if ({e, a, b, c, slot_start, frame_done} !== 6'b000000) begin
            bad++;
            $display("FAIL reset_outputs got e/abc/ss/fd=%b/%b%b%b/%b/%b want 0/000/0/0",
                     e, a, b, c, slot_start, frame_done);
         end
      end
      model_reset();
      rst_n = 1;
   endtask

   task automatic test_full_scan();
      int slot_idx = 0;
      int len = 0;
      int e_hi = 0;
      int fd_cnt = 0;
      int last_fd = -1;
      for (int t = 1; t <= 136; t++) begin
         tick(1'b1, 1'b0, 8'hFF);
         total++;
         if ({e, a, b, c, slot_start, frame_done} !== {exp_e, exp_abc, exp_ss, exp_fd}) begin
            bad++;
            $display("FAIL scan_cycle t=%0t got e/abc/ss/fd=%b/%b%b%b/%b/%b want %b/%b/%b/%b",
                     $time, e, a, b, c, slot_start, frame_done, exp_e, exp_abc, exp_ss, exp_fd);
         end
         if (slot_start) begin
            total++;
            if ({a, b, c} !== 3'(slot_idx % 8)) begin
               bad++;
               $display("FAIL scan_order got abc=%b%b%b want %b", a, b, c, 3'(slot_idx % 8));
            end
            if (slot_idx > 0) begin
               total++;
               if (len != SLOT || e_hi != SLOT - BLANK) begin
                  bad++;
                  $display("FAIL scan_slot_shape got len=%0d e_high=%0d want %0d/%0d",
                           len, e_hi, SLOT, SLOT - BLANK);
               end
            end
            slot_idx++; len = 0; e_hi = 0;
         end
         len++;
         if (e) e_hi++;
         if (frame_done) begin
            total++;
            if (!(slot_start && {a, b, c} == 3'b000) || (last_fd >= 0 && t - last_fd != 64)) begin
               bad++;
               $display("FAIL scan_frame_done got ss=%b abc=%b%b%b gap=%0d want ss=1 abc=000 gap=64",
                        slot_start, a, b, c, t - last_fd);
            end
            fd_cnt++; last_fd = t;
         end
      end
      total++;
      if (fd_cnt != 2) begin
         bad++;
         $display("FAIL scan_frame_count got %0d want 2", fd_cnt);
      end
   endtask

   task automatic test_sparse();
      int prev = -1;
      int gap = 0;
      int n_ss = 0;
      for (int t = 0; t < 64; t++) begin
         tick(1'b1, 1'b0, 8'h24);
         total++;
         if ({e, a, b, c, slot_start, frame_done} !== {exp_e, exp_abc, exp_ss, exp_fd}) begin
            bad++;
            $display("FAIL sparse_cycle t=%0t got e/abc/ss/fd=%b/%b%b%b/%b/%b want %b/%b/%b/%b",
                     $time, e, a, b, c, slot_start, frame_done, exp_e, exp_abc, exp_ss, exp_fd);
         end
         gap++;
         if (slot_start) begin
            n_ss++;
            if (n_ss >= 3) begin
               total++;
               if (int'({a, b, c}) == prev || !({a, b, c} == 3'b010 || {a, b, c} == 3'b101) ||
                   gap != SLOT || frame_done !== ({a, b, c} == 3'b010)) begin
                  bad++;
                  $display("FAIL sparse_alternate got abc=%b%b%b prev=%0d gap=%0d fd=%b want 010/101 alternating gap=8 fd after 101",
                           a, b, c, prev, gap, frame_done);
               end
            end
            prev = int'({a, b, c}); gap = 0;
         end
      end
   endtask

   task automatic test_run_drop();
      int found = 0;
      for (int t = 0; t < 40 && found == 0; t++) begin
         tick(1'b1, 1'b0, 8'h24);
         total++;
         if ({e, a, b, c, slot_start, frame_done} !== {exp_e, exp_abc, exp_ss, exp_fd}) begin
            bad++;
            $display("FAIL drop_cycle t=%0t got e/abc/ss/fd=%b/%b%b%b/%b/%b want %b/%b/%b/%b",
                     $time, e, a, b, c, slot_start, frame_done, exp_e, exp_abc, exp_ss, exp_fd);
         end
         if (slot_start && {a, b, c} == 3'b101) found = 1;
      end
      total++;
      if (found == 0) begin
         bad++;
         $display("FAIL run_drop_wait got no ch5 slot want one within 40 cycles");
      end else begin
         for (int k = 1; k <= 8; k++) begin
            tick((k < 3) ? 1'b1 : 1'b0, 1'b0, 8'h24);
            total++;
            if (k < 8) begin
               if (e !== (k >= BLANK) || {a, b, c} !== 3'b101 || slot_start !== 1'b0) begin
                  bad++;
                  $display("FAIL run_drop_slot k=%0d got e=%b abc=%b%b%b ss=%b want e=%b abc=101 ss=0",
                           k, e, a, b, c, slot_start, (k >= BLANK));
               end
            end else if ({e, a, b, c, slot_start, frame_done} !== 6'b0_101_0_1) begin
               bad++;
               $display("FAIL run_drop_idle got e/abc/ss/fd=%b/%b%b%b/%b/%b want 0/101/0/1",
                        e, a, b, c, slot_start, frame_done);
            end
         end
         repeat (4) begin
            tick(1'b0, 1'b0, 8'h24);
            total++;
            if (e !== 1'b0 || {a, b, c} !== 3'b101 || slot_start !== 1'b0) begin
               bad++;
               $display("FAIL run_drop_hold got e=%b abc=%b%b%b ss=%b want 0/101/0", e, a, b, c, slot_start);
            end
         end
      end
      repeat (20) begin
         tick(1'b1, 1'b0, 8'h00);
         total++;
         if (slot_start !== 1'b0 || e !== 1'b0 || slot_start !== exp_ss) begin
            bad++;
            $display("FAIL zero_mask got ss=%b e=%b want 0/0", slot_start, e);
         end
      end
   endtask

   task automatic test_step();
      tick(1'b0, 1'b1, 8'h04);
      total++;
      if (slot_start !== 1'b1 || {a, b, c} !== 3'b010) begin
         bad++;
         $display("FAIL step_to_ch2 got ss=%b abc=%b%b%b want 1/010", slot_start, a, b, c);
      end
      repeat (10) begin
         tick(1'b0, 1'b0, 8'h04);
         total++;
         if ({e, a, b, c, slot_start, frame_done} !== {exp_e, exp_abc, exp_ss, exp_fd}) begin
            bad++;
            $display("FAIL step_cycle t=%0t got e/abc/ss/fd=%b/%b%b%b/%b/%b want %b/%b/%b/%b",
                     $time, e, a, b, c, slot_start, frame_done, exp_e, exp_abc, exp_ss, exp_fd);
         end
      end
      for (int p = 0; p < 2; p++) begin
         int extra = 0;
         int e_hi = 0;
         tick(1'b0, 1'b1, 8'hFF);
         total++;
         if (slot_start !== 1'b1 || {a, b, c} !== 3'(3 + p) || e !== 1'b0) begin
            bad++;
            $display("FAIL step_start got ss=%b abc=%b%b%b e=%b want 1/%b/0", slot_start, a, b, c, e, 3'(3 + p));
         end
         for (int k = 1; k <= 13; k++) begin
            tick(1'b0, (k == 4) ? 1'b1 : 1'b0, 8'hFF);
            total++;
            if ({e, a, b, c, slot_start, frame_done} !== {exp_e, exp_abc, exp_ss, exp_fd}) begin
               bad++;
               $display("FAIL step_cycle t=%0t got e/abc/ss/fd=%b/%b%b%b/%b/%b want %b/%b/%b/%b",
                        $time, e, a, b, c, slot_start, frame_done, exp_e, exp_abc, exp_ss, exp_fd);
            end
            if (slot_start) extra++;
            if (e) e_hi++;
         end
         total++;
         if (extra != 0 || e_hi != SLOT - BLANK || {a, b, c} !== 3'(3 + p)) begin
            bad++;
            $display("FAIL step_single_slot got extra=%0d e_high=%0d abc=%b%b%b want 0/%0d/%b",
                     extra, e_hi, a, b, c, SLOT - BLANK, 3'(3 + p));
         end
      end
   endtask

   task automatic test_random();
      logic       r = 1'b0;
      logic [7:0] m = 8'hFF;
      for (int t = 0; t < 600; t++) begin
         if ($urandom_range(19) == 0) r = ~r;
         if ($urandom_range(29) == 0) begin
            case ($urandom_range(3))
               0:       m = 8'h00;
               1:       m = 8'(1 << $urandom_range(7));
               default: m = 8'($urandom);
            endcase
         end
         tick(r, ($urandom_range(5) == 0) ? 1'b1 : 1'b0, m);
         total++;
         if ({e, a, b, c, slot_start, frame_done} !== {exp_e, exp_abc, exp_ss, exp_fd}) begin
            bad++;
            $display("FAIL random_cycle t=%0t got e/abc/ss/fd=%b/%b%b%b/%b/%b want %b/%b/%b/%b",
                     $time, e, a, b, c, slot_start, frame_done, exp_e, exp_abc, exp_ss, exp_fd);
         end
      end
   endtask

   task automatic test_async_reset();
      int found = 0;
      for (int t = 0; t < 40 && found == 0; t++) begin
         tick(1'b1, 1'b0, 8'hFF);
         if (e) found = 1;
      end
      total++;
      if (found == 0) begin
         bad++;
         $display("FAIL areset_wait got no DRIVE cycle want one within 40 cycles");
      end
      #1 rst_n = 0;
      #1;
      total++;
      if ({e, a, b, c, slot_start, frame_done} !== 6'b000000) begin
         bad++;
         $display("FAIL areset_immediate got e/abc/ss/fd=%b/%b%b%b/%b/%b want 0/000/0/0",
                  e, a, b, c, slot_start, frame_done);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      model_reset();
      tick(1'b1, 1'b0, 8'hFF);
      total++;
      if (slot_start !== 1'b1 || {a, b, c} !== 3'b000) begin
         bad++;
         $display("FAIL areset_first_channel got ss=%b abc=%b%b%b want 1/000", slot_start, a, b, c);
      end
      repeat (12) begin
         tick(1'b1, 1'b0, 8'hFF);
         total++;
         if ({e, a, b, c, slot_start, frame_done} !== {exp_e, exp_abc, exp_ss, exp_fd}) begin
            bad++;
            $display("FAIL areset_cycle t=%0t got e/abc/ss/fd=%b/%b%b%b/%b/%b want %b/%b/%b/%b",
                     $time, e, a, b, c, slot_start, frame_done, exp_e, exp_abc, exp_ss, exp_fd);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_full_scan();
      test_sparse();
      test_run_drop();
      test_step();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/decoder_scan_sequencer.md
# decoder_scan_sequencer

Registered scan sequencer that drives the enable and 3-bit select inputs (e, a, b, c) of the structural 3-to-8 decoder. It steps through the eight decoder outputs in time slots, skipping masked channels. Each slot starts with a blanking interval (enable low) for glitch-free multiplexed display and LED scanning. It sits directly upstream of the decoder; its outputs connect one-to-one to the decoder's ed/ad/bd/cd inputs.

## Interface
- SLOT_CYC, 100000, clock cycles per channel slot; must be ≥ 2.
- BLANK_CYC, 1000, leading cycles of each slot with e=0; must be ≥ 0 and < SLOT_CYC.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  one clock; reset is asynchronous and active-low.
- run  in  1  level; continuous scanning while high.
- step  in  1  one-cycle pulse; runs exactly one slot when idle and run=0.
- mask  in  8  channel enable; bit n=1 means decoder output dn is scanned.
- e  out  1  decoder enable.
- a  out  1  select MSB.
- b  out  1  select middle bit.
- c  out  1  select LSB.
- slot_start  out  1  one-cycle pulse in the first cycle of every slot.
- frame_done  out  1  one-cycle pulse when the scan wraps past the highest enabled channel.

## Operation
- States: IDLE, BLANK, DRIVE. All outputs are registered.
- Reset (async, rst_n=0): state IDLE; e=0; {a,b,c}=000; slot_start=0; frame_done=0; slot counter=0; internal channel pointer ptr=7, so the first slot selects the lowest enabled channel.
- Next-channel function: cyclic search from ptr+1 (mod 8) upward for the first set mask bit. If only one bit is set, the result is ptr itself. Wrap occurs when the result ≤ ptr.
- IDLE: e=0; {a,b,c} hold their last value.
  - If mask≠0 and (run=1 or step=1): ptr ← next; go to BLANK.
  - If mask=0: remain in IDLE.
- BLANK: e=0; {a,b,c}=ptr; lasts BLANK_CYC cycles, then DRIVE. If BLANK_CYC=0, the slot enters DRIVE directly.
- DRIVE: e=1; {a,b,c}=ptr; lasts SLOT_CYC−BLANK_CYC cycles.
- End of DRIVE:
  - If run=1, mask≠0, and the slot was not a step slot: ptr ← next; start a new slot.
  - Otherwise go to IDLE with e=0.
- frame_done pulses if the channel selected at the end of DRIVE wrapped, or would have wrapped when the sequencer goes idle.
- run falling mid-slot does not truncate the slot; the current slot completes.
- mask changes take effect only at the next channel selection. The current slot is unaffected, even if its bit is cleared.
- step is ignored unless in IDLE with run=0. A step slot returns to IDLE. The next step or run continues from ptr.
- Channel encoding: {a,b,c} = ptr, where a is the MSB (for example, ptr=4 gives a=1, b=0, c=0, which selects d4).

## Timing
- Start latency: run or step sampled high at clock edge k. At edge k+1, slot_start=1 and {a,b,c} are valid.
- e rises at edge k+1+BLANK_CYC.
- Slot length is exactly SLOT_CYC cycles. Back-to-back slots have no gap.
- slot_start coincides with the first BLANK cycle, or the first DRIVE cycle when BLANK_CYC=0.
- frame_done is asserted in the cycle after the last DRIVE cycle of the wrapping slot. That cycle coincides with the next slot_start, or with IDLE entry.
- e is never high while {a,b,c} change. Select changes occur only on slot_start cycles; e is low there unless BLANK_CYC=0.
- The slot counter has width $clog2(SLOT_CYC) and resets to 0 at each slot_start.

## Structure
- Package decoder_scan_pkg:
  - state enum (IDLE/BLANK/DRIVE);
  - NUM_CH=8;
  - chan_t (3-bit).
- Sub-module next_channel_finder:
  - combinational;
  - inputs ptr and mask;
  - outputs next, wrap, and any (mask≠0).
- Top level contains the FSM, slot counter, and output registers.

## Test plan
Bench parameters: SLOT_CYC=8, BLANK_CYC=2.
- Reset check: hold rst_n=0 with run=1 → e=0, abc=000, slot_start=0, frame_done=0.
- Full scan: run=1, mask=FF → abc steps 000,001,…,111,000. Each slot has e=0 for 2 cycles, then e=1 for 6 cycles. frame_done pulses once every 64 cycles, aligned with the abc=000 slot_start.
- Sparse mask: mask=0x24 → abc alternates 010, 101 with a period of 16 cycles. frame_done follows each 101 slot.
- Run drop: deassert run at cycle 3 of the ch5 slot → the slot finishes all 8 cycles, then e=0 and the sequencer goes to IDLE with abc held at 101. mask=0 with run=1 → no slot starts.
- Step: in IDLE with ptr=2 and mask=FF, pulse step once → exactly one slot on abc=011, then IDLE. A second step pulse runs abc=100.
- Async reset: drop rst_n in mid-DRIVE → e=0 immediately (no clock edge needed). After release, run=1 with mask=FF selects abc=000 first.
